// File: rtl/urv_trap_ctrl_pkg.sv
// Shared definitions for the uRV machine-mode trap controller:
// CSR addresses, mstatus/mie bit positions, interrupt cause codes and FSM states.
package urv_trap_ctrl_pkg;

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } trap_state_t;

    localparam logic [11:0] CSR_ID_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_ID_MIE     = 12'h304;
    localparam logic [11:0] CSR_ID_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_ID_MEPC    = 12'h341;
    localparam logic [11:0] CSR_ID_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_ID_MIP     = 12'h344;

    localparam int MSTATUS_MIE     = 3;
    localparam int MSTATUS_MPIE    = 7;
    localparam int MSTATUS_MPP_LSB = 11;

    localparam int MIE_MSIE = 3;
    localparam int MIE_MTIE = 7;
    localparam int MIE_MEIE = 11;

    localparam logic [3:0] CAUSE_IRQ_EXT   = 4'd11;
    localparam logic [3:0] CAUSE_IRQ_TIMER = 4'd7;

    // mcause value for an interrupt: bit 31 set, code in [3:0].
    function automatic logic [31:0] irq_cause(input logic [3:0] code);
        return {1'b1, 27'b0, code};
    endfunction

endpackage

// File: rtl/urv_trap_ctrl_if.sv
// Execute-stage <-> trap controller bundle: commit qualifiers, CSR write port,
// trap/return requests and the redirect back to fetch.
interface urv_trap_ctrl_if;
    logic        x_valid_i;
    logic        x_stall_i;
    logic        x_kill_i;
    logic [31:0] x_pc_i;
    logic        x_is_csr_i;
    logic [11:0] x_csr_sel_i;
    logic [31:0] x_csr_write_value_i;
    logic        x_exception_i;
    logic [3:0]  x_exception_cause_i;
    logic        x_is_mret_i;
    logic        x_redirect_o;
    logic [31:0] x_redirect_pc_o;

    modport master (
        output x_valid_i, x_stall_i, x_kill_i, x_pc_i, x_is_csr_i, x_csr_sel_i,
               x_csr_write_value_i, x_exception_i, x_exception_cause_i, x_is_mret_i,
        input  x_redirect_o, x_redirect_pc_o
    );

    modport slave (
        input  x_valid_i, x_stall_i, x_kill_i, x_pc_i, x_is_csr_i, x_csr_sel_i,
               x_csr_write_value_i, x_exception_i, x_exception_cause_i, x_is_mret_i,
        output x_redirect_o, x_redirect_pc_o
    );
endinterface

// File: rtl/urv_sync_ff.sv
// Multi-stage flip-flop synchroniser for an asynchronous level input.
// Output follows the input after STAGES rising edges.
module urv_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/urv_trap_ctrl.sv
// uRV machine-mode trap controller: owns the trap CSRs, arbitrates exception /
// mret / interrupt redirects and enforces a flush blackout after each redirect.
module urv_trap_ctrl
    import urv_trap_ctrl_pkg::*;
#(
    parameter int          FLUSH_CYCLES = 2,
    parameter int          SYNC_STAGES  = 2,
    parameter logic [31:0] MTVEC_RESET  = 32'h0000_0008
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    urv_trap_ctrl_if.slave exec,
    input  logic          irq_i,
    input  logic          timer_irq_i,
    output logic [31:0]   csr_mstatus_o,
    output logic [31:0]   csr_mip_o,
    output logic [31:0]   csr_mie_o,
    output logic [31:0]   csr_mtvec_o,
    output logic [31:0]   csr_mepc_o,
    output logic [31:0]   csr_mcause_o
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    trap_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        mstatus_mie_q, mstatus_mpie_q;
    logic        meie_q, mtie_q, msie_q;
    logic [31:2] mtvec_q, mepc_q;
    logic        mcause_irq_q;
    logic [3:0]  mcause_code_q;
    logic        irq_sync, timer_sync;

    urv_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ext (
        .clk(clk_i), .rst_n(rst_n_i), .d(irq_i), .q(irq_sync)
    );

    urv_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_timer (
        .clk(clk_i), .rst_n(rst_n_i), .d(timer_irq_i), .q(timer_sync)
    );

    logic        commit, in_run;
    logic        take_exc, take_mret, take_ext, take_timer, take_trap, redirect;
    logic        csr_we;
    logic [31:0] wv;

    assign wv     = exec.x_csr_write_value_i;
    assign commit = exec.x_valid_i & ~exec.x_stall_i & ~exec.x_kill_i;
    assign in_run = (state_q == ST_RUN);

    // Fixed priority: exception, mret, external irq, timer irq.
    assign take_exc   = in_run & commit & exec.x_exception_i;
    assign take_mret  = in_run & commit & ~exec.x_exception_i & exec.x_is_mret_i;
    assign take_ext   = in_run & commit & ~exec.x_exception_i & ~exec.x_is_mret_i
                        & mstatus_mie_q & meie_q & irq_sync;
    assign take_timer = in_run & commit & ~exec.x_exception_i & ~exec.x_is_mret_i & ~take_ext
                        & mstatus_mie_q & mtie_q & timer_sync;
    assign take_trap  = take_exc | take_ext | take_timer;
    assign redirect   = take_trap | take_mret;

    assign csr_we = in_run & commit & exec.x_is_csr_i & ~exec.x_exception_i & ~redirect;

    assign exec.x_redirect_o    = redirect;
    assign exec.x_redirect_pc_o = take_mret ? {mepc_q, 2'b00} : {mtvec_q, 2'b00};

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            meie_q         <= 1'b0;
            mtie_q         <= 1'b0;
            msie_q         <= 1'b0;
            mtvec_q        <= MTVEC_RESET[31:2];
            mepc_q         <= '0;
            mcause_irq_q   <= 1'b0;
            mcause_code_q  <= '0;
        end else if (take_trap) begin
            mepc_q         <= exec.x_pc_i[31:2];
            mcause_irq_q   <= ~take_exc;
            mcause_code_q  <= take_exc ? exec.x_exception_cause_i :
                              take_ext ? CAUSE_IRQ_EXT : CAUSE_IRQ_TIMER;
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
        end else if (take_mret) begin
            mstatus_mie_q  <= mstatus_mpie_q;
            mstatus_mpie_q <= 1'b1;
        end else if (csr_we) begin
            unique case (exec.x_csr_sel_i)
                CSR_ID_MSTATUS: begin
                    mstatus_mie_q  <= wv[MSTATUS_MIE];
                    mstatus_mpie_q <= wv[MSTATUS_MPIE];
                end
                CSR_ID_MIE: begin
                    meie_q <= wv[MIE_MEIE];
                    mtie_q <= wv[MIE_MTIE];
                    msie_q <= wv[MIE_MSIE];
                end
                CSR_ID_MTVEC:  mtvec_q <= wv[31:2];
                CSR_ID_MEPC:   mepc_q  <= wv[31:2];
                CSR_ID_MCAUSE: begin
                    mcause_irq_q  <= wv[31];
                    mcause_code_q <= wv[3:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: defaults first so no path leaves state_d/cnt_d unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (redirect) begin
                    state_d = ST_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == 4'd0) state_d = ST_RUN;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign csr_mstatus_o = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
    assign csr_mie_o     = {20'b0, meie_q, 3'b0, mtie_q, 3'b0, msie_q, 3'b0};
    assign csr_mip_o     = {20'b0, irq_sync, 3'b0, timer_sync, 7'b0};
    assign csr_mtvec_o   = {mtvec_q, 2'b00};
    assign csr_mepc_o    = {mepc_q, 2'b00};
    assign csr_mcause_o  = {mcause_irq_q, 27'b0, mcause_code_q};

    logic unused_bits;
    assign unused_bits = ^{wv[1:0], exec.x_pc_i[1:0]};

endmodule

// File: tb/tb_urv_trap_ctrl.sv
// Directed self-checking bench for urv_trap_ctrl: reset, interrupt/exception
// traps, mret, flush blackout, CSR field masking and asynchronous reset mid-flush.
module tb_urv_trap_ctrl;
    import urv_trap_ctrl_pkg::*;

    localparam int FLUSH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        irq = 1'b0;
    logic        timer = 1'b0;
    logic [31:0] mstatus, mip, mie, mtvec, mepc, mcause;

    int total = 0;
    int bad   = 0;

    urv_trap_ctrl_if bus ();

    urv_trap_ctrl #(
        .FLUSH_CYCLES(FLUSH),
        .SYNC_STAGES (2),
        .MTVEC_RESET (32'h0000_0008)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .exec         (bus.slave),
        .irq_i        (irq),
        .timer_irq_i  (timer),
        .csr_mstatus_o(mstatus),
        .csr_mip_o    (mip),
        .csr_mie_o    (mie),
        .csr_mtvec_o  (mtvec),
        .csr_mepc_o   (mepc),
        .csr_mcause_o (mcause)
    );

    always #5 clk = ~clk;

    task automatic idle();
        bus.x_valid_i = 0; bus.x_stall_i = 0; bus.x_kill_i = 0; bus.x_pc_i = '0;
        bus.x_is_csr_i = 0; bus.x_csr_sel_i = '0; bus.x_csr_write_value_i = '0;
        bus.x_exception_i = 0; bus.x_exception_cause_i = '0; bus.x_is_mret_i = 0;
    endtask

    task automatic drive_insn(input logic [31:0] pc);
        idle();
        bus.x_valid_i = 1; bus.x_pc_i = pc;
    endtask

    task automatic drive_csr(input logic [11:0] sel, input logic [31:0] val, input logic [31:0] pc);
        drive_insn(pc);
        bus.x_is_csr_i = 1; bus.x_csr_sel_i = sel; bus.x_csr_write_value_i = val;
    endtask

    task automatic test_reset();
        idle();
        #12;
        total++; if (mstatus !== 32'h1800) begin bad++; $display("FAIL reset_mstatus got=%h exp=%h", mstatus, 32'h1800); end
        total++; if (mtvec !== 32'h8) begin bad++; $display("FAIL reset_mtvec got=%h exp=%h", mtvec, 32'h8); end
        total++; if ({mie, mip, mepc, mcause} !== 128'h0) begin bad++; $display("FAIL reset_zero mie=%h mip=%h mepc=%h mcause=%h exp=0", mie, mip, mepc, mcause); end
        total++; if (bus.x_redirect_o !== 1'b0) begin bad++; $display("FAIL reset_redirect got=%b exp=0", bus.x_redirect_o); end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_irq_trap();
        @(negedge clk) drive_csr(CSR_ID_MSTATUS, 32'h8, 32'h0);
        @(negedge clk) drive_csr(CSR_ID_MIE, 32'h800, 32'h4);
        @(negedge clk) drive_insn(32'h100); irq = 1'b1;
        #1;
        total++; if (mstatus !== 32'h1808) begin bad++; $display("FAIL wr_mstatus got=%h exp=%h", mstatus, 32'h1808); end
        total++; if (mie !== 32'h800) begin bad++; $display("FAIL wr_mie got=%h exp=%h", mie, 32'h800); end
        total++; if (bus.x_redirect_o !== 1'b0) begin bad++; $display("FAIL irq_sync0 got=%b exp=0", bus.x_redirect_o); end
        @(negedge clk); #1;
        total++; if (bus.x_redirect_o !== 1'b0 || mip !== 32'h0) begin bad++; $display("FAIL irq_sync1 redirect=%b mip=%h exp 0/0", bus.x_redirect_o, mip); end
        @(negedge clk); #1;
        total++; if (mip !== 32'h800) begin bad++; $display("FAIL irq_mip got=%h exp=%h", mip, 32'h800); end
        total++; if (bus.x_redirect_o !== 1'b1 || bus.x_redirect_pc_o !== 32'h8) begin bad++; $display("FAIL irq_redirect got=%b/%h exp=1/00000008", bus.x_redirect_o, bus.x_redirect_pc_o); end
        @(negedge clk); #1;
        total++; if (mepc !== 32'h100) begin bad++; $display("FAIL irq_mepc got=%h exp=%h", mepc, 32'h100); end
        total++; if (mcause !== 32'h8000000B) begin bad++; $display("FAIL irq_mcause got=%h exp=%h", mcause, 32'h8000000B); end
        total++; if (mstatus !== 32'h1880) begin bad++; $display("FAIL irq_mstatus got=%h exp=%h", mstatus, 32'h1880); end
    endtask

    // Entered in the first flush cycle after the interrupt trap.
    task automatic test_mret_and_blackout();
        bus.x_is_mret_i = 1'b1;
        #1;
        for (int i = 0; i < FLUSH; i++) begin
            total++; if (bus.x_redirect_o !== 1'b0) begin bad++; $display("FAIL mret_blackout%0d got=%b exp=0", i, bus.x_redirect_o); end
            @(negedge clk); #1;
        end
        total++; if (bus.x_redirect_o !== 1'b1 || bus.x_redirect_pc_o !== 32'h100) begin bad++; $display("FAIL mret_redirect got=%b/%h exp=1/00000100", bus.x_redirect_o, bus.x_redirect_pc_o); end
        @(negedge clk) drive_insn(32'h104);
        #1;
        total++; if (mstatus !== 32'h1888) begin bad++; $display("FAIL mret_mstatus got=%h exp=%h", mstatus, 32'h1888); end
        for (int i = 0; i < FLUSH; i++) begin
            total++; if (bus.x_redirect_o !== 1'b0) begin bad++; $display("FAIL irq_blackout%0d got=%b exp=0", i, bus.x_redirect_o); end
            @(negedge clk); #1;
        end
        total++; if (bus.x_redirect_o !== 1'b1 || bus.x_redirect_pc_o !== 32'h8) begin bad++; $display("FAIL irq_after_flush got=%b/%h exp=1/00000008", bus.x_redirect_o, bus.x_redirect_pc_o); end
        @(negedge clk) idle();
        #1;
        total++; if (mepc !== 32'h104 || mstatus !== 32'h1880) begin bad++; $display("FAIL irq2_state mepc=%h mstatus=%h exp 00000104/00001880", mepc, mstatus); end
    endtask

    task automatic test_mret_vs_irq();
        @(negedge clk);
        @(negedge clk) drive_csr(CSR_ID_MSTATUS, 32'h8, 32'h108);
        @(negedge clk) drive_insn(32'h10c); bus.x_is_mret_i = 1'b1;
        #1;
        total++; if (mstatus !== 32'h1808) begin bad++; $display("FAIL mvi_mstatus got=%h exp=%h", mstatus, 32'h1808); end
        total++; if (bus.x_redirect_o !== 1'b1 || bus.x_redirect_pc_o !== 32'h104) begin bad++; $display("FAIL mvi_redirect got=%b/%h exp=1/00000104", bus.x_redirect_o, bus.x_redirect_pc_o); end
        @(negedge clk) idle();
        #1;
        total++; if (mstatus !== 32'h1880 || mcause !== 32'h8000000B) begin bad++; $display("FAIL mvi_state mstatus=%h mcause=%h exp 00001880/8000000b", mstatus, mcause); end
    endtask

    task automatic test_exception_priority();
        timer = 1'b1;
        @(negedge clk);
        @(negedge clk) drive_csr(CSR_ID_MIE, 32'h880, 32'h1f0);
        @(negedge clk) drive_csr(CSR_ID_MSTATUS, 32'h8, 32'h1f4);
        @(negedge clk) drive_csr(CSR_ID_MSTATUS, 32'h0, 32'h200);
        bus.x_exception_i = 1'b1; bus.x_exception_cause_i = 4'd2;
        #1;
        total++; if (mip !== 32'h880 || mie !== 32'h880 || mstatus !== 32'h1808) begin bad++; $display("FAIL exc_pre mip=%h mie=%h mstatus=%h exp 880/880/1808", mip, mie, mstatus); end
        total++; if (bus.x_redirect_o !== 1'b1 || bus.x_redirect_pc_o !== 32'h8) begin bad++; $display("FAIL exc_redirect got=%b/%h exp=1/00000008", bus.x_redirect_o, bus.x_redirect_pc_o); end
        @(negedge clk) idle(); irq = 1'b0;
        #1;
        total++; if (mcause !== 32'h2 || mepc !== 32'h200) begin bad++; $display("FAIL exc_state mcause=%h mepc=%h exp 00000002/00000200", mcause, mepc); end
        total++; if (mstatus !== 32'h1880) begin bad++; $display("FAIL exc_mstatus got=%h exp=%h", mstatus, 32'h1880); end
    endtask

    task automatic test_timer_irq();
        @(negedge clk);
        @(negedge clk) drive_csr(CSR_ID_MSTATUS, 32'h8, 32'h2f0);
        @(negedge clk) drive_csr(CSR_ID_MSTATUS, 32'h88, 32'h300);
        bus.x_stall_i = 1'b1;
        #1;
        total++; if (mip !== 32'h80) begin bad++; $display("FAIL tmr_mip got=%h exp=%h", mip, 32'h80); end
        total++; if (bus.x_redirect_o !== 1'b0) begin bad++; $display("FAIL tmr_stall got=%b exp=0", bus.x_redirect_o); end
        bus.x_stall_i = 1'b0; bus.x_valid_i = 1'b0;
        #1;
        total++; if (bus.x_redirect_o !== 1'b0) begin bad++; $display("FAIL tmr_novalid got=%b exp=0", bus.x_redirect_o); end
        bus.x_valid_i = 1'b1;
        #1;
        total++; if (bus.x_redirect_o !== 1'b1 || bus.x_redirect_pc_o !== 32'h8) begin bad++; $display("FAIL tmr_redirect got=%b/%h exp=1/00000008", bus.x_redirect_o, bus.x_redirect_pc_o); end
        @(negedge clk) idle();
        #1;
        total++; if (mcause !== 32'h80000007 || mepc !== 32'h300) begin bad++; $display("FAIL tmr_state mcause=%h mepc=%h exp 80000007/00000300", mcause, mepc); end
        total++; if (mstatus !== 32'h1880) begin bad++; $display("FAIL tmr_csr_drop mstatus=%h exp=%h", mstatus, 32'h1880); end
    endtask

    task automatic test_field_masks();
        @(negedge clk);
        @(negedge clk) drive_csr(CSR_ID_MIE, 32'hFFFFFFFF, 32'h400);
        @(negedge clk) drive_csr(CSR_ID_MTVEC, 32'h203, 32'h404);
        @(negedge clk) drive_csr(CSR_ID_MIP, 32'hFFFFFFFF, 32'h408);
        @(negedge clk) drive_csr(CSR_ID_MEPC, 32'h123, 32'h40c);
        @(negedge clk) idle();
        #1;
        total++; if (mie !== 32'h888) begin bad++; $display("FAIL mask_mie got=%h exp=%h", mie, 32'h888); end
        total++; if (mtvec !== 32'h200) begin bad++; $display("FAIL mask_mtvec got=%h exp=%h", mtvec, 32'h200); end
        total++; if (mip !== 32'h80) begin bad++; $display("FAIL mask_mip got=%h exp=%h", mip, 32'h80); end
        total++; if (mepc !== 32'h120) begin bad++; $display("FAIL mask_mepc got=%h exp=%h", mepc, 32'h120); end
    endtask

    task automatic test_reset_mid_flush();
        @(negedge clk) drive_insn(32'h500);
        bus.x_exception_i = 1'b1; bus.x_exception_cause_i = 4'd4;
        #1;
        total++; if (bus.x_redirect_o !== 1'b1 || bus.x_redirect_pc_o !== 32'h200) begin bad++; $display("FAIL rst_pre_redirect got=%b/%h exp=1/00000200", bus.x_redirect_o, bus.x_redirect_pc_o); end
        @(negedge clk) idle();
        #2 rst_n = 1'b0;
        #1;
        total++; if (mtvec !== 32'h8 || mstatus !== 32'h1800) begin bad++; $display("FAIL rst_async mtvec=%h mstatus=%h exp 00000008/00001800", mtvec, mstatus); end
        total++; if ({mie, mip, mepc, mcause} !== 128'h0) begin bad++; $display("FAIL rst_async_zero mie=%h mip=%h mepc=%h mcause=%h exp=0", mie, mip, mepc, mcause); end
        #1 rst_n = 1'b1;
        @(negedge clk) drive_insn(32'h504);
        bus.x_exception_i = 1'b1; bus.x_exception_cause_i = 4'd3;
        #1;
        total++; if (bus.x_redirect_o !== 1'b1 || bus.x_redirect_pc_o !== 32'h8) begin bad++; $display("FAIL rst_run_after got=%b/%h exp=1/00000008", bus.x_redirect_o, bus.x_redirect_pc_o); end
        @(negedge clk) idle();
    endtask

    initial begin
        test_reset();
        test_irq_trap();
        test_mret_and_blackout();
        test_mret_vs_irq();
        test_exception_priority();
        test_timer_irq();
        test_field_masks();
        test_reset_mid_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
